// File: rtl/hex_word_printer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hex_word_printer
// Description : Prints a NIBBLES-digit word as uppercase ASCII hex, MSB first,
//               over a valid/ready character stream. Optional macro
//               HEX_WORD_PRINTER_NEWLINE_EN appends CR (0x0D) and LF (0x0A).
// Revision    : 1.0 - initial release
// ============================================================================
module hex_word_printer #(
  parameter int NIBBLES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4*NIBBLES-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [6:0]           out_char,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

`ifdef HEX_WORD_PRINTER_NEWLINE_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_CR   = 2'd2,
    S_LF   = 2'd3
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [6:0]      char_q,  char_d;
  logic            valid_q, valid_d;

  logic            w_accept;
  logic            w_consume;
  logic [W-1:0]    w_shifted;

  // Digits 10..15 land on 'A'..'F': 0x41 + (n - 10) == 0x37 + n.
  function automatic logic [6:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (7'h30 + {3'b000, n}) : (7'h37 + {3'b000, n});
  endfunction

  // in_ready is forced low combinationally while reset is held.
  assign in_ready  = (state_q == S_IDLE) & ~reset;
  assign busy      = (state_q != S_IDLE);
  assign out_char  = char_q;
  assign out_valid = valid_q;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = valid_q & out_ready;
  assign w_shifted = shift_q << 4;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      char_q  <= 7'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          shift_d = in_data;
          cnt_d   = C_LAST;
          char_d  = hex_char(in_data[W-1 -: 4]);
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_consume) begin
          shift_d = w_shifted;
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            char_d = hex_char(w_shifted[W-1 -: 4]);
          end else begin
`ifdef HEX_WORD_PRINTER_NEWLINE_EN
            char_d  = 7'h0D;
            state_d = S_CR;
`else
            valid_d = 1'b0;
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef HEX_WORD_PRINTER_NEWLINE_EN
      S_CR: begin
        if (w_consume) begin
          char_d  = 7'h0A;
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (w_consume) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
